demux4_buf: RTL
===============

DEMUX4_BUF -- requirements
Module: demux4_buf

Interface
REQ-001 Parameter WIDTH, default 4, data width per beat.
REQ-002 Parameter CNT_W, default 8, width of each per-channel transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 d  input  WIDTH  input beat data.
REQ-006 sel  input  2  destination channel when rr_en=0.
REQ-007 rr_en  input  1  1 = round-robin routing (sel ignored), 0 = sel routing.
REQ-008 in_valid  input  1  input beat present.
REQ-009 in_ready  output  1  input beat accepted this cycle when in_valid=1.
REQ-010 y  output  4 x WIDTH  per-channel held data.
REQ-011 out_valid  output  4  per-channel data valid.
REQ-012 out_ready  input  4  per-channel consumer ready.
REQ-013 cur_ch  output  2  channel the next beat routes to.
REQ-014 xfer_cnt  output  4 x CNT_W  per-channel count of beats delivered (out_valid & out_ready).

Function
REQ-015 cur_ch SHALL equal sel when rr_en=0, and the round-robin pointer rr_ptr when rr_en=1.
REQ-016 Each channel SHALL hold exactly one entry (full flag plus WIDTH data register).
REQ-017 in_ready SHALL equal ~full[cur_ch] | out_ready[cur_ch] (combinational; same-cycle drain frees slot).
REQ-018 Accept = in_valid & in_ready; on accept, channel cur_ch SHALL load d and set full at the next edge.
REQ-019 out_valid[i] SHALL equal full[i]; y[i] SHALL equal the stored data and SHALL remain stable while out_valid[i]=1 and out_ready[i]=0.
REQ-020 Drain of channel i = full[i] & out_ready[i]; full[i] SHALL clear next edge unless simultaneously reloaded.
REQ-021 Simultaneous drain and accept on the same channel SHALL leave full=1 with the new data.
REQ-022 Channels not addressed by cur_ch SHALL drain independently in the same cycle as an accept.
REQ-023 Latency d -> y[i] SHALL be exactly one cycle; no data combinational from d to y.
REQ-024 rr_ptr SHALL advance by 1 modulo 4 (3 -> 0) on each accept while rr_en=1; it SHALL hold otherwise.
REQ-025 Toggling rr_en SHALL not reset rr_ptr.
REQ-026 xfer_cnt[i] SHALL increment on each drain of channel i and saturate at 2^CNT_W-1 (no wrap).
REQ-027 With in_valid=0, no state other than drains and counters SHALL change.

Reset
REQ-028 rst_n=0 SHALL immediately clear all full flags, out_valid=0, y=0, rr_ptr=0, xfer_cnt=0.
REQ-029 Reset asserted mid-transfer SHALL discard held entries without a delivery or count.
REQ-030 in_ready after reset SHALL be 1 (all slots empty).

Structure
REQ-031 Shared package demux_pkg SHALL hold NCH=4, typedef ch_idx_t (2 bits), and default WIDTH/CNT_W constants.
REQ-032 One sub-module demux_slot SHALL implement a single channel's entry, full flag, and saturating counter; demux4_buf instantiates four.
REQ-033 Routing decode and rr_ptr SHALL live in demux4_buf.

Verification
REQ-034 Sel route: rr_en=0, sel=2, d=4'hA, in_valid=1, out_ready=0 -> next cycle out_valid=4'b0100, y[2]=4'hA; others unchanged.
REQ-035 Backpressure: channel 1 full, out_ready[1]=0, sel=1, in_valid=1 -> in_ready=0, y[1] stable; raise out_ready[1] -> in_ready=1 same cycle, new data next cycle, xfer_cnt[1]=1.
REQ-036 Round-robin: rr_en=1, four consecutive beats 1,2,3,4, all out_ready=1 -> y[0..3]=1,2,3,4 in order, rr_ptr back to 0.
REQ-037 Counter saturation: CNT_W=2, five drains on channel 0 -> xfer_cnt[0]=3.
REQ-038 Async reset: rst_n low between edges with channels full -> out_valid=0 and y=0 before next edge; rr_ptr=0 after release.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the four-channel buffered demultiplexer.
package demux_pkg;

  // Number of output channels.
  localparam int NCH = 4;

  // Default beat data width and per-channel transfer counter width.
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // Channel index, wide enough to address NCH channels.
  typedef logic [1:0] ch_idx_t;

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// One output channel: a single-entry holding register with a full flag,
// plus a saturating count of beats delivered to the consumer.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             out_ready,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  logic drain;

  // A held beat leaves the slot whenever the consumer is ready.
  assign drain = full & out_ready;

  // Entry, full flag and delivery counter; a load wins over a drain so a
  // same-cycle drain+load leaves the slot full with the new beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, because y must read zero while
      // reset is asserted rather than show a stale beat.
      full <= 1'b0;
      data <= '0;
      cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      if (load) begin
        full <= 1'b1;
        data <= d;
      end else if (drain) begin
        full <= 1'b0;
      end
      if (drain && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule : demux_slot

// File: rtl/demux4_buf.sv
// Four-channel buffered demultiplexer. Each input beat is routed either by
// sel or by a round-robin pointer into one of four single-entry channel
// slots; each slot drains independently under its own out_ready.
module demux4_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          d,
  input  logic [1:0]                sel,
  input  logic                      rr_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NCH-1:0][WIDTH-1:0] y,
  output logic [NCH-1:0]            out_valid,
  input  logic [NCH-1:0]            out_ready,
  output logic [1:0]                cur_ch,
  output logic [NCH-1:0][CNT_W-1:0] xfer_cnt
);

  ch_idx_t        rr_ptr;
  logic [NCH-1:0] full;
  logic [NCH-1:0] load;
  logic           accept;

  // Destination of the next beat: round-robin pointer or explicit select.
  assign cur_ch = rr_en ? rr_ptr : sel;

  // The addressed slot can take a beat if empty or draining this cycle.
  assign in_ready = ~full[cur_ch] | out_ready[cur_ch];
  assign accept   = in_valid & in_ready;

  // Decode the accepted beat into a one-hot load for the addressed slot.
  always_comb begin
    // NOTE: default assignment first so no path leaves load unassigned,
    // which would otherwise infer a latch.
    load         = '0;
    load[cur_ch] = accept;
  end

  // Round-robin pointer steps on every accept made in round-robin mode and
  // is otherwise held, including across rr_en toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept && rr_en) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end

  assign out_valid = full;

  // One holding slot per output channel.
  for (genvar i = 0; i < NCH; i++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .d         (d),
      .out_ready (out_ready[i]),
      .full      (full[i]),
      .data      (y[i]),
      .cnt       (xfer_cnt[i])
    );
  end

endmodule : demux4_buf
